// File: rtl/call_stack.sv
// Return-address stack for CALL/RET: DEPTH x AW entries, sticky error flags.
// Ports: clock, reset (async high), push/pop/pushAddress/clearErrors in;
//        topAddress, count, full, empty, overflow, underflow out.
module call_stack #(
   parameter int AW    = 12,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [AW-1:0]              pushAddress,
   input  logic                       clearErrors,
   output logic [AW-1:0]              topAddress,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] sp;
   logic [PW-1:0] spNext;
   logic [AW-1:0] entries [DEPTH];
   logic [IW-1:0] topIdx;
   logic [IW-1:0] wrIdx;
   logic          wrEn;
   logic          ovfSet;
   logic          unfSet;
   logic          replaceTop;
   logic          pushReq;

   // Outputs depend on registered state only.
   assign count  = sp;
   assign full   = (sp == PW'(DEPTH));
   assign empty  = (sp == '0);
   assign topIdx = IW'(sp - PW'(1));
   // Storage is not reset; masking on empty hides stale contents.
   assign topAddress = empty ? '0 : entries[topIdx];

   // Simultaneous push+pop replaces the top; on an empty stack it is a push.
   assign replaceTop = push & pop & ~empty;
   assign pushReq    = push & ~replaceTop;

   always_comb begin
      wrEn   = 1'b0;
      wrIdx  = sp[IW-1:0];
      spNext = sp;
      ovfSet = 1'b0;
      unfSet = 1'b0;
      unique case (1'b1)
         replaceTop: begin
            wrEn  = 1'b1;
            wrIdx = topIdx;
         end
         (pushReq & ~full): begin
            wrEn   = 1'b1;
            spNext = sp + PW'(1);
         end
         (pushReq & full): begin
            ovfSet = 1'b1;
         end
         (~push & pop & ~empty): begin
            spNext = sp - PW'(1);
         end
         (~push & pop & empty): begin
            unfSet = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         sp        <= spNext;
         // A new error in the clearing cycle keeps the flag set.
         overflow  <= ovfSet | (overflow & ~clearErrors);
         underflow <= unfSet | (underflow & ~clearErrors);
      end
   end

   always_ff @(posedge clock) begin
      if (wrEn) begin
         entries[wrIdx] <= pushAddress;
      end
   end

endmodule
